// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall bus layout,
// divider defaults and divider FSM encodings.
package pipe_ctrl_pkg;

    typedef logic [4:0] stall_bus_t;

    localparam int STL_PC    = 0;
    localparam int STL_IFID  = 1;
    localparam int STL_IDEX  = 2;
    localparam int STL_EXMEM = 3;
    localparam int STL_WB    = 4;

    localparam int DIV_CYCLES_DEF = 32;

    localparam logic [1:0] DIV_IDLE = 2'b00;
    localparam logic [1:0] DIV_BUSY = 2'b01;
    localparam logic [1:0] DIV_DONE = 2'b10;

    typedef enum logic [1:0] {
        SRC_IF  = 2'd0,
        SRC_ID  = 2'd1,
        SRC_EX  = 2'd2,
        SRC_MEM = 2'd3
    } stall_src_e;

    // A stall raised by a stage holds that stage and every stage upstream of it.
    function automatic stall_bus_t stall_mask(input stall_src_e src);
        stall_bus_t m;
        m = '0;
        for (int b = STL_PC; b <= STL_WB; b++) begin
            m[b] = (b <= int'(src));
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_ctrl_div_seq.sv
// Sequencer for the iterative divider in EX: init, DIV_CYCLES steps, then
// a done cycle that is held while EX/MEM is frozen.
//
// state    | meaning
// ---------+------------------------------------------------------------
// DIV_IDLE | no divide in flight; init fires here when a divide can start
// DIV_BUSY | divider iterating, EX stalled, counter counts down to zero
// DIV_DONE | result valid to EX; held while the EX/MEM register is held
module div_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic flush_i,
    input  logic hold_i,
    output logic init_o,
    output logic step_o,
    output logic done_o,
    output logic busy_o,
    output logic ex_stall_o
);

    localparam int CW = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign init_o     = ~rst & (state_q == DIV_IDLE) & start_i & ~flush_i & ~hold_i;
    assign step_o     = (state_q == DIV_BUSY);
    assign done_o     = (state_q == DIV_DONE);
    assign busy_o     = (state_q != DIV_IDLE);
    assign ex_stall_o = init_o | step_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (init_o) begin
                        state_d = DIV_BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
                DIV_BUSY: begin
                    if (cnt_q == '0) begin
                        state_d = DIV_DONE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                DIV_DONE: begin
                    if (!hold_i) begin
                        state_d = DIV_IDLE;
                    end
                end
                default: begin
                    state_d = DIV_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, sequences the EX divider
// and issues exception flushes (deferred while MEM waits on the data bus).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_stallreq_i,
    input  logic             id_stallreq_i,
    input  logic             mem_stallreq_i,
    input  logic             ex_div_start_i,
    input  logic             exc_req_i,
    input  logic [31:0]      exc_target_i,
    output stall_bus_t       stall_o,
    output logic             flush_o,
    output logic [31:0]      flush_pc_o,
    output logic             div_init_o,
    output logic             div_step_o,
    output logic             div_done_o,
    output logic             div_busy_o
);

    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        ex_stall;
    logic        mem_hold;

    // A flush can only leave once MEM has finished its bus access.
    assign flush_o    = ~rst & ~mem_stallreq_i & (exc_req_i | pend_q);
    assign flush_pc_o = flush_o ? (exc_req_i ? exc_target_i : pend_pc_q) : 32'h0;

    // Same value as the EX/MEM hold bit, kept separate so the divider does not
    // loop back through the stall vector it helps to build.
    assign mem_hold = ~rst & mem_stallreq_i;

    div_seq #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_seq (
        .clk        (clk),
        .rst        (rst),
        .start_i    (ex_div_start_i),
        .flush_i    (flush_o),
        .hold_i     (mem_hold),
        .init_o     (div_init_o),
        .step_o     (div_step_o),
        .done_o     (div_done_o),
        .busy_o     (div_busy_o),
        .ex_stall_o (ex_stall)
    );

    always_comb begin
        stall_o = '0;
        if (!rst && !flush_o) begin
            if (mem_stallreq_i) begin
                stall_o = stall_mask(SRC_MEM);
            end else if (ex_stall) begin
                stall_o = stall_mask(SRC_EX);
            end else if (id_stallreq_i) begin
                stall_o = stall_mask(SRC_ID);
            end else if (if_stallreq_i) begin
                stall_o = stall_mask(SRC_IF);
            end
        end
    end

    always_comb begin
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        if (mem_stallreq_i) begin
            if (exc_req_i) begin
                pend_d    = 1'b1;
                pend_pc_d = exc_target_i;
            end
        end else begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q    <= 1'b0;
            pend_pc_q <= 32'h0;
        end else begin
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a cycle-age behavioural model checked on
// every falling edge, plus hand-computed literal expectations.
module tb_pipe_ctrl;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_stallreq = 1'b0;
    logic        id_stallreq = 1'b0;
    logic        mem_stallreq = 1'b0;
    logic        ex_div_start = 1'b0;
    logic        exc_req = 1'b0;
    logic [31:0] exc_target = 32'h0;

    logic [4:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        div_init, div_step, div_done, div_busy;

    int checks = 0;
    int failures = 0;

    pipe_ctrl #(.DIV_CYCLES(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_stallreq_i  (if_stallreq),
        .id_stallreq_i  (id_stallreq),
        .mem_stallreq_i (mem_stallreq),
        .ex_div_start_i (ex_div_start),
        .exc_req_i      (exc_req),
        .exc_target_i   (exc_target),
        .stall_o        (stall),
        .flush_o        (flush),
        .flush_pc_o     (flush_pc),
        .div_init_o     (div_init),
        .div_step_o     (div_step),
        .div_done_o     (div_done),
        .div_busy_o     (div_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_age counts cycles since the divide's init cycle (1..N stepping,
    // >N done); m_idle marks no divide in flight.
    bit          m_idle = 1'b1;
    int          m_age = 0;
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_pc = 32'h0;

    logic        e_flush, e_init, e_step, e_done, e_busy;
    logic [31:0] e_pc;
    logic [4:0]  e_stall;

    always_comb begin
        int src;
        src     = -1;
        e_flush = !rst && !mem_stallreq && (exc_req || m_pend);
        e_pc    = e_flush ? (exc_req ? exc_target : m_pend_pc) : 32'h0;
        e_init  = !rst && m_idle && ex_div_start && !e_flush && !mem_stallreq;
        e_step  = !rst && !m_idle && (m_age >= 1) && (m_age <= N);
        e_done  = !rst && !m_idle && (m_age > N);
        e_busy  = !rst && !m_idle;
        if (if_stallreq) src = 0;
        if (id_stallreq) src = 1;
        if (e_init || e_step) src = 2;
        if (mem_stallreq) src = 3;
        if (rst || e_flush || src < 0) e_stall = 5'd0;
        else e_stall = 5'((1 << (src + 1)) - 1);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idle    <= 1'b1;
            m_age     <= 0;
            m_pend    <= 1'b0;
            m_pend_pc <= 32'h0;
        end else begin
            if (e_flush) begin
                m_idle <= 1'b1;
                m_age  <= 0;
            end else if (m_idle) begin
                if (e_init) begin
                    m_idle <= 1'b0;
                    m_age  <= 1;
                end
            end else if (m_age <= N) begin
                m_age <= m_age + 1;
            end else if (!mem_stallreq) begin
                m_idle <= 1'b1;
                m_age  <= 0;
            end
            if (mem_stallreq) begin
                if (exc_req) begin
                    m_pend    <= 1'b1;
                    m_pend_pc <= exc_target;
                end
            end else begin
                m_pend <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_stall", 32'(stall), 32'(e_stall));
        chk("m_flush", 32'(flush), 32'(e_flush));
        chk("m_flush_pc", flush_pc, e_pc);
        chk("m_div_init", 32'(div_init), 32'(e_init));
        chk("m_div_step", 32'(div_step), 32'(e_step));
        chk("m_div_done", 32'(div_done), 32'(e_done));
        chk("m_div_busy", 32'(div_busy), 32'(e_busy));
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int done_at;
        // reset with live requests: outputs must stay quiet
        if_stallreq  = 1'b1;
        ex_div_start = 1'b1;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_init", 32'(div_init), 32'h0);
        chk("rst_busy", 32'(div_busy), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        nxt();
        rst = 1'b0; if_stallreq = 1'b0; ex_div_start = 1'b0;

        // stall priority
        if_stallreq = 1'b1; id_stallreq = 1'b1;
        @(negedge clk); chk("stall_if_id", 32'(stall), 32'h03);
        nxt(); mem_stallreq = 1'b1;
        @(negedge clk); chk("stall_if_id_mem", 32'(stall), 32'h0f);
        nxt(); mem_stallreq = 1'b0; id_stallreq = 1'b0;
        @(negedge clk); chk("stall_if", 32'(stall), 32'h01);
        nxt(); if_stallreq = 1'b0;
        @(negedge clk); chk("stall_none", 32'(stall), 32'h00);

        // plain divide
        nxt(); ex_div_start = 1'b1;
        @(negedge clk);
        chk("div0_init", 32'(div_init), 32'h1);
        chk("div0_stall", 32'(stall), 32'h07);
        for (int c = 1; c <= N; c++) begin
            nxt();
            @(negedge clk);
            chk("divb_step", 32'(div_step), 32'h1);
            chk("divb_stall", 32'(stall), 32'h07);
            chk("divb_done", 32'(div_done), 32'h0);
        end
        nxt();
        @(negedge clk);
        chk("div_done", 32'(div_done), 32'h1);
        chk("div_done_stall", 32'(stall), 32'h00);
        nxt(); ex_div_start = 1'b0;
        @(negedge clk);
        chk("div_after_busy", 32'(div_busy), 32'h0);

        // MEM stall across the DONE cycle
        nxt(); ex_div_start = 1'b1;
        for (int c = 0; c < N; c++) nxt();
        nxt(); mem_stallreq = 1'b1;
        @(negedge clk);
        chk("hold_done0", 32'(div_done), 32'h1);
        chk("hold_stall", 32'(stall), 32'h0f);
        for (int c = 0; c < 2; c++) begin
            nxt();
            @(negedge clk); chk("hold_done", 32'(div_done), 32'h1);
        end
        nxt(); mem_stallreq = 1'b0;
        @(negedge clk); chk("hold_done_last", 32'(div_done), 32'h1);
        nxt(); ex_div_start = 1'b0;
        @(negedge clk);
        chk("hold_idle_done", 32'(div_done), 32'h0);
        chk("hold_idle_busy", 32'(div_busy), 32'h0);

        // MEM stall during BUSY, then exception flush mid-divide
        nxt(); ex_div_start = 1'b1;
        nxt(); mem_stallreq = 1'b1;
        @(negedge clk);
        chk("busy_mem_stall", 32'(stall), 32'h0f);
        chk("busy_mem_step", 32'(div_step), 32'h1);
        nxt(); mem_stallreq = 1'b0; exc_req = 1'b1; exc_target = 32'hBFC00380;
        @(negedge clk);
        chk("exc_flush", 32'(flush), 32'h1);
        chk("exc_pc", flush_pc, 32'hBFC00380);
        chk("exc_stall", 32'(stall), 32'h00);
        nxt(); exc_req = 1'b0; exc_target = 32'h0; ex_div_start = 1'b0;
        @(negedge clk);
        chk("exc_busy_next", 32'(div_busy), 32'h0);

        // deferred flush behind a MEM stall
        nxt(); mem_stallreq = 1'b1; exc_req = 1'b1; exc_target = 32'h80000180;
        @(negedge clk); chk("pend_flush0", 32'(flush), 32'h0);
        nxt(); exc_req = 1'b0; exc_target = 32'h0;
        @(negedge clk); chk("pend_flush1", 32'(flush), 32'h0);
        nxt();
        @(negedge clk); chk("pend_flush2", 32'(flush), 32'h0);
        nxt(); mem_stallreq = 1'b0;
        @(negedge clk);
        chk("pend_flush", 32'(flush), 32'h1);
        chk("pend_pc", flush_pc, 32'h80000180);
        nxt();
        @(negedge clk); chk("pend_clear", 32'(flush), 32'h0);

        // second exception while pending overwrites the target
        nxt(); mem_stallreq = 1'b1; exc_req = 1'b1; exc_target = 32'h80000200;
        nxt(); exc_target = 32'h80000380;
        nxt(); mem_stallreq = 1'b0; exc_req = 1'b0; exc_target = 32'h0;
        @(negedge clk);
        chk("ovr_flush", 32'(flush), 32'h1);
        chk("ovr_pc", flush_pc, 32'h80000380);

        // exception and divide start together in IDLE
        nxt(); ex_div_start = 1'b1; exc_req = 1'b1; exc_target = 32'hBFC00200;
        @(negedge clk);
        chk("sim_flush", 32'(flush), 32'h1);
        chk("sim_init", 32'(div_init), 32'h0);
        nxt(); ex_div_start = 1'b0; exc_req = 1'b0; exc_target = 32'h0;
        @(negedge clk); chk("sim_busy", 32'(div_busy), 32'h0);

        // async reset mid-BUSY, then a fresh divide
        nxt(); ex_div_start = 1'b1;
        nxt(); nxt();
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(div_busy), 32'h0);
        chk("arst_step", 32'(div_step), 32'h0);
        chk("arst_init", 32'(div_init), 32'h0);
        chk("arst_stall", 32'(stall), 32'h0);
        nxt(); rst = 1'b0;
        done_at = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_at < 0 && div_done) done_at = c;
            nxt();
        end
        chk("fresh_occupancy", 32'(done_at + 1), 32'(N + 2));
        ex_div_start = 1'b0;
        nxt(); nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
